// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the 3-bit-opcode CPU.
// Optional memory-ack timeout to a sticky FAULT state is enabled by `CPU_SEQ_TIMEOUT_EN.
module cpu_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [2:0] opcode,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       reg_write,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       instr_done,
  output logic       fault,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd7;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_LDI = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_STR = 3'b100;
  localparam logic [2:0] OP_JMP = 3'b101;

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  logic [2:0] r_op;
  logic       w_timeout;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Opcode latch: the IR is read only once, in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= 3'b000;
    end else if (r_state == S_DECODE) begin
      r_op <= opcode;
    end else begin
      r_op <= r_op;
    end
  end

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  // Wait counter: restarts on every state change, counts unacked request cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else if (w_next_state != r_state) begin
      r_cnt <= {CW{1'b0}};
    end else if (mem_req && !mem_ack) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // A same-cycle ack beats the timeout
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1)) && !mem_ack;
  assign fault     = (r_state == S_FAULT);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
  assign fault            = 1'b0;
`endif

  // Next-state logic; run is only consulted at instruction boundaries
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (run) w_next_state = S_FETCH;
        else     w_next_state = S_IDLE;
      end
      S_FETCH: begin
        if (mem_ack)        w_next_state = S_DECODE;
        else if (w_timeout) w_next_state = S_FAULT;
        else                w_next_state = S_FETCH;
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        if (r_op == OP_STR) w_next_state = S_MEM;
        else if (run)       w_next_state = S_FETCH;
        else                w_next_state = S_IDLE;
      end
      S_MEM: begin
        if (mem_ack) begin
          if (run) w_next_state = S_FETCH;
          else     w_next_state = S_IDLE;
        end else if (w_timeout) begin
          w_next_state = S_FAULT;
        end else begin
          w_next_state = S_MEM;
        end
      end
      S_FAULT: w_next_state = S_FAULT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from registered state and latched opcode
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    instr_done = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ack;
        pc_inc  = mem_ack;
      end
      S_EXEC: begin
        instr_done = (r_op != OP_STR);
        case (r_op)
          OP_ADD: begin
            reg_write = 1'b1;
            alu_op    = 2'b00;
          end
          OP_SUB: begin
            reg_write = 1'b1;
            alu_op    = 2'b11;
          end
          OP_XOR: begin
            reg_write = 1'b1;
            alu_op    = 2'b01;
          end
          OP_LDI: begin
            reg_write = 1'b1;
            alu_op    = 2'b10;
            alu_src   = 1'b1;
          end
          OP_JMP: begin
            pc_load = 1'b1;
            alu_op  = 2'b10;
            alu_src = 1'b1;
          end
          OP_STR: begin
            alu_op  = 2'b00;
            alu_src = 1'b1;
          end
          default: begin
            reg_write = 1'b0;
          end
        endcase
      end
      S_MEM: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        addr_sel   = 1'b1;
        alu_op     = 2'b00;
        alu_src    = 1'b1;
        instr_done = mem_ack;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed table, hand sequences and
// randomized instruction streams checked against an instruction-level model.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [2:0] opcode;
  logic       mem_ack;
  logic       mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_write;
  logic [1:0] alu_op;
  logic       alu_src, instr_done, fault;
  logic [2:0] state;

  cpu_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .reg_write(reg_write), .alu_op(alu_op),
    .alu_src(alu_src), .instr_done(instr_done), .fault(fault), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       instr_done;
    logic       fault;
    logic [2:0] state;
  } outs_t;

  typedef struct {
    logic       run;
    logic       ack;
    logic [2:0] opc;
    outs_t      exp;
  } cyc_t;

  typedef struct {
    logic [2:0] op;
    int         wf;
    int         wm;
    int         len;
    logic       rw;
    int         pl;
    logic [1:0] aop;
    logic       asrc;
    int         mwe;
  } vec_t;

  outs_t got;
  assign got = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_write,
                alu_op, alu_src, instr_done, fault, state};

  int   n_checks = 0;
  int   n_fail   = 0;
  cyc_t q[$];
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n   = 1'b0;
    run     = 1'b0;
    mem_ack = 1'b0;
    opcode  = 3'b000;
    #1;
    chk("reset_outputs", 32'(got), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Model: expected outputs for a given phase of an instruction
  function automatic outs_t phase_o(input logic [2:0] st);
    outs_t o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic outs_t exec_o(input logic [2:0] op);
    outs_t o = phase_o(3'd3);
    case (op)
      3'b000: o.reg_write = 1'b1;
      3'b001: begin o.reg_write = 1'b1; o.alu_op = 2'b11; end
      3'b011: begin o.reg_write = 1'b1; o.alu_op = 2'b01; end
      3'b010: begin o.reg_write = 1'b1; o.alu_op = 2'b10; o.alu_src = 1'b1; end
      3'b101: begin o.pc_load = 1'b1; o.alu_op = 2'b10; o.alu_src = 1'b1; end
      3'b100: o.alu_src = 1'b1;
      default: o.alu_op = 2'b00;
    endcase
    o.instr_done = (op != 3'b100);
    return o;
  endfunction

  task automatic push_idle(input logic r);
    cyc_t c;
    c.run = r;
    c.ack = 1'($urandom_range(0, 1));
    c.opc = 3'($urandom_range(0, 7));
    c.exp = phase_o(3'd0);
    q.push_back(c);
  endtask

  // Expand one instruction into its expected cycle sequence
  task automatic plan(input logic [2:0] op, input int wf, input int wm,
                      input logic run_end, input int idle_n);
    cyc_t c;
    for (int i = 0; i <= wf; i++) begin
      c.run = 1'($urandom_range(0, 1));
      c.ack = (i == wf);
      c.opc = 3'($urandom_range(0, 7));
      c.exp = phase_o(3'd1);
      c.exp.mem_req = 1'b1;
      c.exp.ir_load = c.ack;
      c.exp.pc_inc  = c.ack;
      q.push_back(c);
    end
    c.run = 1'($urandom_range(0, 1));
    c.ack = 1'($urandom_range(0, 1));
    c.opc = op;
    c.exp = phase_o(3'd2);
    q.push_back(c);
    c.run = (op == 3'b100) ? 1'($urandom_range(0, 1)) : run_end;
    c.ack = 1'($urandom_range(0, 1));
    c.opc = 3'($urandom_range(0, 7));
    c.exp = exec_o(op);
    q.push_back(c);
    if (op == 3'b100) begin
      for (int i = 0; i <= wm; i++) begin
        c.run = (i == wm) ? run_end : 1'($urandom_range(0, 1));
        c.ack = (i == wm);
        c.opc = 3'($urandom_range(0, 7));
        c.exp = phase_o(3'd4);
        c.exp.mem_req    = 1'b1;
        c.exp.mem_we     = 1'b1;
        c.exp.addr_sel   = 1'b1;
        c.exp.alu_src    = 1'b1;
        c.exp.instr_done = c.ack;
        q.push_back(c);
      end
    end
    if (!run_end) begin
      for (int i = 0; i < idle_n; i++) push_idle(1'b0);
      push_idle(1'b1);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         done_i = -1;
    int         pl_cnt = 0;
    int         mwe_cnt = 0;
    logic       rw_s = 1'b0;
    logic [1:0] aop_s = 2'b00;
    logic       as_s = 1'b0;
    reset_dut();
    run = 1'b1;
    for (int i = 0; i < 24 && done_i < 0; i++) begin
      mem_ack = (i == v.wf + 1) || (v.op == 3'b100 && i == v.wf + 4 + v.wm);
      opcode  = (i == v.wf + 2) ? v.op : ~v.op;
      @(negedge clk);
      if (i == v.wf + 3) begin
        rw_s  = reg_write;
        aop_s = alu_op;
        as_s  = alu_src;
      end
      pl_cnt  += int'(pc_load);
      mwe_cnt += int'(mem_we);
      if (instr_done) done_i = i;
      @(posedge clk); #1;
    end
    chk($sformatf("vec%0d_len", idx), done_i, v.len);
    chk($sformatf("vec%0d_reg_write", idx), 32'(rw_s), 32'(v.rw));
    chk($sformatf("vec%0d_pc_load_cycles", idx), pl_cnt, v.pl);
    chk($sformatf("vec%0d_alu_op", idx), 32'(aop_s), 32'(v.aop));
    chk($sformatf("vec%0d_alu_src", idx), 32'(as_s), 32'(v.asrc));
    chk($sformatf("vec%0d_mem_we_cycles", idx), mwe_cnt, v.mwe);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b000, 0, 0, 3, 1'b1, 0, 2'b00, 1'b0, 0};
    vecs[1] = '{3'b001, 1, 0, 4, 1'b1, 0, 2'b11, 1'b0, 0};
    vecs[2] = '{3'b011, 0, 0, 3, 1'b1, 0, 2'b01, 1'b0, 0};
    vecs[3] = '{3'b010, 2, 0, 5, 1'b1, 0, 2'b10, 1'b1, 0};
    vecs[4] = '{3'b101, 0, 0, 3, 1'b0, 1, 2'b10, 1'b1, 0};
    vecs[5] = '{3'b110, 0, 0, 3, 1'b0, 0, 2'b00, 1'b0, 0};
    vecs[6] = '{3'b111, 1, 0, 4, 1'b0, 0, 2'b00, 1'b0, 0};
    vecs[7] = '{3'b100, 0, 2, 6, 1'b0, 0, 2'b00, 1'b1, 3};
    vecs[8] = '{3'b100, 0, 0, 4, 1'b0, 0, 2'b00, 1'b1, 1};

    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; opcode = 3'b000;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Back-to-back ADD with ack tied high: 3-cycle period, no IDLE gaps
    reset_dut();
    run = 1'b1; mem_ack = 1'b1; opcode = 3'b000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_mem_req_%0d", i), 32'(mem_req), 32'(i % 3 == 1));
      chk($sformatf("b2b_ir_load_%0d", i), 32'(ir_load), 32'(i % 3 == 1));
      chk($sformatf("b2b_done_%0d", i), 32'(instr_done), 32'(i > 0 && i % 3 == 0));
      chk($sformatf("b2b_reg_write_%0d", i), 32'(reg_write), 32'(i > 0 && i % 3 == 0));
      @(posedge clk); #1;
    end

    // run dropped during DECODE of XOR
    reset_dut();
    run = 1'b1; mem_ack = 1'b1; opcode = 3'b011;
    @(posedge clk); #1;
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rundrop_reg_write", 32'(reg_write), 32'd1);
    chk("rundrop_alu_op", 32'(alu_op), 32'd1);
    chk("rundrop_done", 32'(instr_done), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rundrop_idle_state", 32'(state), 32'd0);
    chk("rundrop_idle_req", 32'(mem_req), 32'd0);
    run = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rundrop_refetch_state", 32'(state), 32'd1);
    chk("rundrop_refetch_req", 32'(mem_req), 32'd1);

    // Asynchronous reset in the middle of a store
    reset_dut();
    run = 1'b1; mem_ack = 1'b0; opcode = 3'b100;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midmem_state", 32'(state), 32'd4);
    chk("midmem_we", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midmem_async_outputs", 32'(got), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_idle", 32'(state), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_reset_fetch", 32'(state), 32'd1);
    chk("after_reset_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;

`ifdef CPU_SEQ_TIMEOUT_EN
    // No ack in FETCH: fault after 4 wait cycles, sticky
    reset_dut();
    run = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("timeout_state", 32'(state), 32'd7);
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("fault_sticky", 32'(state), 32'd7);
    // Ack on the 4th wait cycle wins over the timeout
    reset_dut();
    run = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    mem_ack = 1'b1;
    @(negedge clk);
    chk("late_ack_ir_load", 32'(ir_load), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("late_ack_state", 32'(state), 32'd2);
    chk("late_ack_fault", 32'(fault), 32'd0);
    @(posedge clk); #1;
`else
    // Without the timeout the sequencer waits indefinitely
    reset_dut();
    run = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("wait_forever_state", 32'(state), 32'd1);
    chk("wait_forever_fault", 32'(fault), 32'd0);
    @(posedge clk); #1;
`endif

    // Randomized instruction stream against the model
    reset_dut();
    push_idle(1'b0);
    push_idle(1'b0);
    push_idle(1'b1);
    for (int n = 0; n < 40; n++) begin
      plan(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 2));
    end
    for (int i = 0; i < q.size(); i++) begin
      run     = q[i].run;
      mem_ack = q[i].ack;
      opcode  = q[i].opc;
      @(negedge clk);
      chk($sformatf("rand_cyc%0d", i), 32'(got), 32'(q[i].exp));
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 3-bit-opcode CPU. It steps each instruction through fetch, decode, execute and optional memory phases, and drives PC, IR, register-file, ALU and memory-port controls. It replaces single-cycle decode with a handshaked memory interface, so memory latency may vary. It sits between the instruction register/PC and the shared memory port.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum wait cycles for `mem_ack` before fault (1..255).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 allows instruction issue.
- `opcode`  in  3  IR opcode field, valid from the cycle after `ir_load`.
- `mem_ack`  in  1  memory completion; may be asserted in the same cycle as `mem_req`.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  1 = store, 0 = instruction fetch.
- `addr_sel`  out  1  0 = PC drives address, 1 = ALU result drives address.
- `ir_load`  out  1  one-cycle pulse that loads IR.
- `pc_inc`  out  1  one-cycle pulse, PC+1.
- `pc_load`  out  1  one-cycle pulse, PC <- imm (JMP).
- `reg_write`  out  1  one-cycle register-file write strobe.
- `alu_op`  out  2  00 ADD, 01 XOR, 10 PASS-B, 11 SUB.
- `alu_src`  out  1  0 = reg B, 1 = imm.
- `instr_done`  out  1  pulse on the last cycle of each retired instruction.
- `fault`  out  1  sticky memory-timeout flag.
- `state`  out  3  current state code, for debug.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, FAULT=7.
- IDLE: all strobes 0. Go to FETCH when `run`=1; otherwise stay.
- FETCH: `mem_req`=1, `mem_we`=0, `addr_sel`=0. When `mem_ack`=1: `ir_load`=1, `pc_inc`=1, next state DECODE.
- DECODE: register `opcode` into internal `op_q`, then go to EXEC. All outputs derive from `op_q`; the IR is not re-read after this.
- EXEC, by `op_q`:
  - 000 ADD: `reg_write`=1, `alu_op`=00, `alu_src`=0.
  - 001 SUB: `reg_write`=1, `alu_op`=11, `alu_src`=0.
  - 011 XOR: `reg_write`=1, `alu_op`=01, `alu_src`=0.
  - 010 LDI: `reg_write`=1, `alu_op`=10, `alu_src`=1.
  - 101 JMP: `pc_load`=1, `alu_op`=10, `alu_src`=1.
  - 110, 111 NOP: no strobes.
  - 100 STR: `alu_src`=1, `alu_op`=00, next state MEM.
- After EXEC, every opcode except STR asserts `instr_done` and goes to FETCH if `run`=1, else IDLE.
- MEM: `mem_req`=1, `mem_we`=1, `addr_sel`=1, with `alu_src`/`alu_op` held as in EXEC. When `mem_ack`=1: `instr_done`=1, next state FETCH or IDLE, chosen by `run` as above.
- `run` is sampled only at instruction boundaries. Deasserting it mid-instruction completes that instruction first.
- `mem_ack` is ignored outside FETCH and MEM.
- Wait counter: cleared on entering FETCH or MEM; increments each cycle `mem_req`=1 and `mem_ack`=0. Counter width is $clog2(TIMEOUT+1).

## Timing
- Reset (async assert, sync release): state=IDLE, `op_q`=000, counter=0, every output 0, `state`=0.
- Outputs are Moore-style, decoded from registered state and `op_q`, with one exception: `ir_load`, `pc_inc` and `instr_done` in FETCH/MEM are gated by `mem_ack` in the same cycle.
- Minimum latency with zero-wait ack: ALU/LDI/JMP/NOP take 3 cycles (FETCH, DECODE, EXEC); STR takes 4.
- Each cycle without ack adds 1 cycle to FETCH or MEM.
- `mem_req` stays high until the ack cycle inclusive and drops the next cycle, unless FETCH immediately follows MEM.
- Back-to-back instructions insert no IDLE cycle while `run`=1.
- Reset asserted mid-access drops `mem_req` immediately (async). The memory side must discard the in-flight access.

## Configuration
- `CPU_SEQ_TIMEOUT_EN` defined:
  - In FETCH/MEM, if the counter reaches `TIMEOUT` with no ack, the next state is FAULT.
  - FAULT: `fault`=1, all strobes 0. Only `rst_n` exits it.
  - An ack arriving in the same cycle the counter reaches `TIMEOUT` wins: no fault.
- `CPU_SEQ_TIMEOUT_EN` undefined:
  - No counter logic; the sequencer waits forever.
  - `fault` is tied to 0 and FAULT is unreachable.

## Test plan
- Reset, `run`=1, ack tied high, opcode=000 → `mem_req`/`ir_load`/`pc_inc` at cycle 1, `reg_write`=1 with `alu_op`=00 at cycle 3, `instr_done` at cycle 3; repeats every 3 cycles.
- STR (100) with ack delayed 2 cycles in MEM → `mem_we`=1 and `addr_sel`=1 held 3 cycles, `instr_done` on the ack cycle, 6-cycle instruction.
- JMP (101) → `pc_load`=1 for exactly 1 cycle in EXEC, `reg_write`=0, `alu_op`=10; opcodes 110 and 111 → no strobes, `instr_done` still pulses.
- `run` dropped during DECODE of an XOR → XOR completes with `reg_write`, then IDLE with `mem_req`=0; `run` reasserted → FETCH next cycle.
- `CPU_SEQ_TIMEOUT_EN` defined, `TIMEOUT`=4, ack never arrives in FETCH → FAULT after 4 wait cycles with `fault`=1; ack at exactly the 4th cycle → no fault.
- `rst_n` pulled low mid-MEM → all outputs 0 asynchronously and `state`=0; after release, fetch resumes when `run`=1.
